// File: rtl/compl_pkg.sv
// compl_pkg: shared state encoding and default width for the complement scheduler
package compl_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/compl1.sv
// compl1: shared datapath, one's complement (cpl=1) or pass-through (cpl=0)
// Ports: Inp operand, cpl operation select, Out result (WIDTH bits, no extension)
module compl1 import compl_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] Inp,
    input  logic             cpl,
    output logic [WIDTH-1:0] Out
);
    assign Out = cpl ? ~Inp : Inp;
endmodule

// File: rtl/compl_sched.sv
// compl_sched: round-robin scheduler sharing one compl1 unit between two requesters
// Ports: clk, reset (async, active-high); req/data/cpl per requester in, gnt per requester out;
//        out_valid/out_data/out_src result held until out_ready; done_cnt counts accepted results
module compl_sched import compl_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             cpl0,
    input  logic             cpl1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [7:0]       done_cnt
);
    state_t state, state_n;
    logic [WIDTH-1:0] op_data, op_data_n, out_data_n, res;
    logic op_cpl, op_cpl_n, sel, sel_n, last_src, last_src_n;
    logic gnt0_n, gnt1_n, out_valid_n, out_src_n, pick;
    logic [7:0] done_cnt_n;

    compl1 #(.WIDTH(WIDTH)) u_compl1 (.Inp(op_data), .cpl(op_cpl), .Out(res));

    // a lone requester wins; on a tie the side that was not served last wins
    assign pick = (req0 & req1) ? ~last_src : req1;

    always_comb begin
        state_n     = state;
        op_data_n   = op_data;
        op_cpl_n    = op_cpl;
        sel_n       = sel;
        last_src_n  = last_src;
        gnt0_n      = 1'b0;
        gnt1_n      = 1'b0;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_src_n   = out_src;
        done_cnt_n  = done_cnt;
        case (state)
            IDLE: if (req0 | req1) begin
                op_data_n = pick ? data1 : data0;
                op_cpl_n  = pick ? cpl1 : cpl0;
                sel_n     = pick;
                gnt0_n    = ~pick;
                gnt1_n    = pick;
                state_n   = EXEC;
            end
            EXEC: begin
                out_valid_n = 1'b1;
                out_data_n  = res;
                out_src_n   = sel;
                state_n     = WAIT;
            end
            WAIT: if (out_ready) begin
                out_valid_n = 1'b0;
                last_src_n  = sel;
                done_cnt_n  = done_cnt + 8'd1;
                state_n     = IDLE;
            end
            default: begin
                out_valid_n = 1'b0;
                out_data_n  = '0;
                out_src_n   = 1'b0;
                state_n     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_data   <= '0;
            op_cpl    <= 1'b0;
            sel       <= 1'b0;
            last_src  <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            done_cnt  <= 8'd0;
        end else begin
            state     <= state_n;
            op_data   <= op_data_n;
            op_cpl    <= op_cpl_n;
            sel       <= sel_n;
            last_src  <= last_src_n;
            gnt0      <= gnt0_n;
            gnt1      <= gnt1_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_src   <= out_src_n;
            done_cnt  <= done_cnt_n;
        end
    end
endmodule
